oflow_registration_multi: RTL and testbench

- Parametrised successor of the per-object registration stage.
- Accepts one current object at a time: features plus target score-board row.
- Consumes a stream of NUM_CH-wide candidate (score, id) beats from the score-calc array, tracks the two minimum scores, and allocates a fresh ID on first frame or when the best score exceeds a programmable threshold.
- Writes {features, assigned id} into an internal ROWS-deep feature memory, presents the top-2 result to the score board/conflict resolver, and provides a 1-cycle-latency readback port for the PEs.

---
 rtl/oflow_registration_multi.sv | 219 +++++++++++++++++++++
 tb/tb_oflow_registration_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_registration_multi.sv
// Per-object registration stage: merges candidate beats into a top-2 tracker, assigns or
// allocates an object ID, writes {features, id} into a feature memory and serves 1-cycle readback.
module oflow_registration_multi #(
  parameter int unsigned FEAT_W  = 120,
  parameter int unsigned ID_W    = 12,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned ROWS    = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned FRAME_W = 16,
  localparam int unsigned ROW_W  = $clog2(ROWS)
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic [FRAME_W-1:0]        frame_num,
  input  logic                      alloc_en,
  input  logic [SCORE_W-1:0]        new_id_thresh,
  input  logic                      id_clear,
  input  logic                      obj_valid,
  output logic                      obj_ready,
  input  logic [FEAT_W-1:0]         obj_feat,
  input  logic [ROW_W-1:0]          obj_row,
  input  logic                      cand_valid,
  output logic                      cand_ready,
  input  logic [NUM_CH-1:0]         cand_mask,
  input  logic [NUM_CH*SCORE_W-1:0] cand_score,
  input  logic [NUM_CH*ID_W-1:0]    cand_id,
  input  logic                      cand_last,
  output logic                      res_valid,
  output logic [ROW_W-1:0]          res_row,
  output logic [SCORE_W-1:0]        res_score0,
  output logic [ID_W-1:0]           res_id0,
  output logic [SCORE_W-1:0]        res_score1,
  output logic [ID_W-1:0]           res_id1,
  output logic                      res_new_id,
  output logic                      done_registration,
  input  logic                      rd_en,
  input  logic [ROW_W-1:0]          rd_row,
  output logic [FEAT_W+ID_W-1:0]    rd_data
);
  localparam int unsigned MEM_W = FEAT_W + ID_W;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DECIDE  = 2'd2;
  localparam logic [1:0] S_WRITE   = 2'd3;
  localparam logic [ID_W-1:0] ID_ONE = ID_W'(1);
  localparam logic [ID_W-1:0] ID_MAX = '1;

  logic [1:0]         state, state_nxt;
  logic [FEAT_W-1:0]  feat_q, feat_nxt;
  logic [ROW_W-1:0]   row_q, row_nxt;
  logic               first_q, first_nxt, seen_q, seen_nxt;
  logic [SCORE_W-1:0] best_score, best_score_nxt, sec_score, sec_score_nxt;
  logic [ID_W-1:0]    best_id, best_id_nxt, sec_id, sec_id_nxt;
  logic [ID_W-1:0]    next_id, next_id_nxt;
  logic [SCORE_W-1:0] res_score0_nxt, res_score1_nxt;
  logic [ID_W-1:0]    res_id0_nxt, res_id1_nxt;
  logic [ROW_W-1:0]   res_row_nxt;
  logic               res_new_id_nxt, res_valid_nxt, alloc;
  logic [SCORE_W-1:0] m_best_score, m_sec_score, ch_score;
  logic [ID_W-1:0]    m_best_id, m_sec_id, ch_id;
  logic [MEM_W-1:0]   mem [ROWS];

  assign done_registration = res_valid;

  // Top-2 merge of the current beat; strict less-than so ties keep the earlier entry.
  always_comb begin
    m_best_score = best_score;
    m_best_id    = best_id;
    m_sec_score  = sec_score;
    m_sec_id     = sec_id;
    ch_score     = '0;
    ch_id        = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      ch_score = cand_score[c*SCORE_W +: SCORE_W];
      ch_id    = cand_id[c*ID_W +: ID_W];
      if (cand_mask[c]) begin
        if (ch_score < m_best_score) begin
          m_sec_score  = m_best_score;
          m_sec_id     = m_best_id;
          m_best_score = ch_score;
          m_best_id    = ch_id;
        end else if (ch_score < m_sec_score) begin
          m_sec_score = ch_score;
          m_sec_id    = ch_id;
        end
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt      = state;
    feat_nxt       = feat_q;
    row_nxt        = row_q;
    first_nxt      = first_q;
    seen_nxt       = seen_q;
    best_score_nxt = best_score;
    best_id_nxt    = best_id;
    sec_score_nxt  = sec_score;
    sec_id_nxt     = sec_id;
    next_id_nxt    = next_id;
    res_score0_nxt = res_score0;
    res_id0_nxt    = res_id0;
    res_score1_nxt = res_score1;
    res_id1_nxt    = res_id1;
    res_row_nxt    = res_row;
    res_new_id_nxt = res_new_id;
    res_valid_nxt  = 1'b0;
    alloc          = 1'b0;
    case (state)
      S_IDLE: begin
        if (obj_valid && obj_ready) begin
          feat_nxt       = obj_feat;
          row_nxt        = obj_row;
          first_nxt      = (frame_num == '0);
          seen_nxt       = 1'b0;
          best_score_nxt = '1;
          best_id_nxt    = '0;
          sec_score_nxt  = '1;
          sec_id_nxt     = '0;
          state_nxt      = (frame_num == '0) ? S_DECIDE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cand_valid && cand_ready) begin
          best_score_nxt = m_best_score;
          best_id_nxt    = m_best_id;
          sec_score_nxt  = m_sec_score;
          sec_id_nxt     = m_sec_id;
          seen_nxt       = seen_q | (|cand_mask);
          if (cand_last) state_nxt = S_DECIDE;
        end
      end
      S_DECIDE: begin
        state_nxt      = S_WRITE;
        res_valid_nxt  = 1'b1;
        res_row_nxt    = row_q;
        res_new_id_nxt = 1'b0;
        if (first_q || !seen_q) begin
          alloc          = 1'b1;
          res_score0_nxt = '0;
          res_score1_nxt = '0;
          res_id1_nxt    = '0;
        end else if (alloc_en && (best_score > new_id_thresh)) begin
          alloc          = 1'b1;
          res_score0_nxt = best_score;
          res_score1_nxt = best_score;
          res_id1_nxt    = best_id;
        end else begin
          res_score0_nxt = best_score;
          res_id0_nxt    = best_id;
          res_score1_nxt = sec_score;
          res_id1_nxt    = sec_id;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // ID 0 is reserved, so the counter wraps from all-ones back to 1.
    if (alloc) begin
      res_id0_nxt    = next_id;
      res_new_id_nxt = 1'b1;
      next_id_nxt    = (next_id == ID_MAX) ? ID_ONE : next_id + ID_ONE;
    end
    if (id_clear) next_id_nxt = ID_ONE;
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state      <= S_IDLE;
      feat_q     <= '0;
      row_q      <= '0;
      first_q    <= 1'b0;
      seen_q     <= 1'b0;
      best_score <= '1;
      best_id    <= '0;
      sec_score  <= '1;
      sec_id     <= '0;
      next_id    <= ID_ONE;
      res_valid  <= 1'b0;
      res_row    <= '0;
      res_score0 <= '0;
      res_id0    <= '0;
      res_score1 <= '0;
      res_id1    <= '0;
      res_new_id <= 1'b0;
      obj_ready  <= 1'b0;
      cand_ready <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      feat_q     <= feat_nxt;
      row_q      <= row_nxt;
      first_q    <= first_nxt;
      seen_q     <= seen_nxt;
      best_score <= best_score_nxt;
      best_id    <= best_id_nxt;
      sec_score  <= sec_score_nxt;
      sec_id     <= sec_id_nxt;
      next_id    <= next_id_nxt;
      res_valid  <= res_valid_nxt;
      res_row    <= res_row_nxt;
      res_score0 <= res_score0_nxt;
      res_id0    <= res_id0_nxt;
      res_score1 <= res_score1_nxt;
      res_id1    <= res_id1_nxt;
      res_new_id <= res_new_id_nxt;
      obj_ready  <= (state_nxt == S_IDLE);
      cand_ready <= (state_nxt == S_COLLECT);
      if (rd_en) rd_data <= mem[rd_row];
    end
  end

  // Feature memory has no reset; a read in the write cycle sees the old word.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) mem[res_row] <= {feat_q, res_id0};
  end

endmodule

// File: tb/tb_oflow_registration_multi.sv
// Randomised bench for oflow_registration_multi against a list-based top-2 / ID-allocation model.
module tb_oflow_registration_multi;
  localparam int unsigned FEAT_W = 120, ID_W = 12, SCORE_W = 16, ROWS = 32, NUM_CH = 2, FRAME_W = 16;
  localparam int unsigned ROW_W = 5, WID_W = 3, MAXB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_N;

  logic [FRAME_W-1:0] frame_num;
  logic alloc_en, id_clear, obj_valid, obj_ready, cand_valid, cand_ready, cand_last;
  logic [SCORE_W-1:0] new_id_thresh, res_score0, res_score1;
  logic [FEAT_W-1:0] obj_feat;
  logic [ROW_W-1:0] obj_row, res_row, rd_row;
  logic [NUM_CH-1:0] cand_mask;
  logic [NUM_CH*SCORE_W-1:0] cand_score;
  logic [NUM_CH*ID_W-1:0] cand_id;
  logic res_valid, res_new_id, done_registration, rd_en;
  logic [ID_W-1:0] res_id0, res_id1;
  logic [FEAT_W+ID_W-1:0] rd_data;

  logic w_id_clear, w_obj_valid, w_obj_ready, w_cand_ready, w_res_valid, w_res_new_id, w_done;
  logic [ROW_W-1:0] w_obj_row, w_res_row;
  logic [SCORE_W-1:0] w_res_score0, w_res_score1;
  logic [WID_W-1:0] w_res_id0, w_res_id1;
  logic [FEAT_W+WID_W-1:0] w_rd_data;

  oflow_registration_multi dut (
    .clk(clk), .reset_N(reset_N), .frame_num(frame_num), .alloc_en(alloc_en),
    .new_id_thresh(new_id_thresh), .id_clear(id_clear), .obj_valid(obj_valid), .obj_ready(obj_ready),
    .obj_feat(obj_feat), .obj_row(obj_row), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_mask(cand_mask), .cand_score(cand_score), .cand_id(cand_id), .cand_last(cand_last),
    .res_valid(res_valid), .res_row(res_row), .res_score0(res_score0), .res_id0(res_id0),
    .res_score1(res_score1), .res_id1(res_id1), .res_new_id(res_new_id),
    .done_registration(done_registration), .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data));

  oflow_registration_multi #(.ID_W(WID_W)) wdut (
    .clk(clk), .reset_N(reset_N), .frame_num(16'd0), .alloc_en(1'b0),
    .new_id_thresh(16'd0), .id_clear(w_id_clear), .obj_valid(w_obj_valid), .obj_ready(w_obj_ready),
    .obj_feat(120'd5), .obj_row(w_obj_row), .cand_valid(1'b0), .cand_ready(w_cand_ready),
    .cand_mask(2'b00), .cand_score(32'd0), .cand_id(6'd0), .cand_last(1'b0),
    .res_valid(w_res_valid), .res_row(w_res_row), .res_score0(w_res_score0), .res_id0(w_res_id0),
    .res_score1(w_res_score1), .res_id1(w_res_id1), .res_new_id(w_res_new_id),
    .done_registration(w_done), .rd_en(1'b0), .rd_row(5'd0), .rd_data(w_rd_data));

  int n_checks = 0, n_pass = 0;
  int nb, lat, m_next;
  logic [NUM_CH-1:0] b_mask [MAXB];
  logic [NUM_CH*SCORE_W-1:0] b_score [MAXB];
  logic [NUM_CH*ID_W-1:0] b_id [MAXB];
  logic [FEAT_W+ID_W-1:0] m_mem [ROWS];
  logic [FEAT_W+ID_W-1:0] m_old;
  bit m_known [ROWS];
  int e_s0, e_i0, e_s1, e_i1;
  bit e_new;
  logic [SCORE_W-1:0] cap_s0, cap_s1;
  logic [ID_W-1:0] cap_i0, cap_i1;
  logic [ROW_W-1:0] cap_row;
  logic cap_new;

  task automatic set_beat(input int b, input logic [1:0] m, input int s0, input int i0, input int s1, input int i1);
    b_mask[b] = m;
    b_score[b] = {SCORE_W'(s1), SCORE_W'(s0)};
    b_id[b] = {ID_W'(i1), ID_W'(i0)};
  endtask

  // Reference: flatten all valid candidates in arrival order, pick first-occurring minimum and runner-up.
  task automatic model_decide(input bit first, input bit aen, input int th);
    int sq[$];
    int iq[$];
    int bi, si;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < int'(NUM_CH); c++)
        if (b_mask[b][c]) begin
          sq.push_back(int'(b_score[b][c*SCORE_W +: SCORE_W]));
          iq.push_back(int'(b_id[b][c*ID_W +: ID_W]));
        end
    bi = -1; si = -1;
    for (int k = 0; k < sq.size(); k++) if (bi < 0 || sq[k] < sq[bi]) bi = k;
    for (int k = 0; k < sq.size(); k++) if (k != bi && (si < 0 || sq[k] < sq[si])) si = k;
    e_new = 1'b0;
    if (first || sq.size() == 0) begin
      e_new = 1'b1; e_s0 = 0; e_s1 = 0; e_i1 = 0;
    end else if (aen && sq[bi] > th) begin
      e_new = 1'b1; e_s0 = sq[bi]; e_s1 = sq[bi]; e_i1 = iq[bi];
    end else begin
      e_s0 = sq[bi]; e_i0 = iq[bi];
      e_s1 = (si < 0) ? 65535 : sq[si];
      e_i1 = (si < 0) ? 0 : iq[si];
    end
    if (e_new) begin
      e_i0 = m_next;
      m_next = (m_next == 4095) ? 1 : m_next + 1;
    end
  endtask

  // Drives one object through handshake and beats; captures the result during res_valid.
  task automatic run_object(input int fr, input logic [FEAT_W-1:0] ft, input int rw, input bit rdw);
    int cnt;
    frame_num = FRAME_W'(fr); obj_feat = ft; obj_row = ROW_W'(rw); obj_valid = 1'b1;
    cnt = 0;
    while (!obj_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!obj_ready) begin n_checks++; $display("FAIL obj_handshake: obj_ready never rose"); end
    @(posedge clk); #1;
    obj_valid = 1'b0;
    if (fr != 0)
      for (int b = 0; b < nb; b++) begin
        cand_valid = 1'b1; cand_mask = b_mask[b]; cand_score = b_score[b];
        cand_id = b_id[b]; cand_last = (b == nb - 1);
        cnt = 0;
        while (!cand_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        if (!cand_ready) begin n_checks++; $display("FAIL cand_handshake: cand_ready never rose"); end
        @(posedge clk); #1;
      end
    cand_valid = 1'b0; cand_last = 1'b0; cand_mask = '0;
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    cap_s0 = res_score0; cap_i0 = res_id0; cap_s1 = res_score1; cap_i1 = res_id1;
    cap_new = res_new_id; cap_row = res_row;
    if (rdw) begin rd_en = 1'b1; rd_row = ROW_W'(rw); end
    @(posedge clk); #1;
    rd_en = 1'b0;
    m_old = m_mem[rw];
    m_mem[rw] = {ft, ID_W'(e_i0)};
    m_known[rw] = 1'b1;
  endtask

  task automatic do_read(input int rw);
    rd_en = 1'b1; rd_row = ROW_W'(rw);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_N = 1'b0;
    frame_num = '0; alloc_en = 0; new_id_thresh = '0; id_clear = 0; obj_valid = 0; obj_feat = '0;
    obj_row = '0; cand_valid = 0; cand_mask = '0; cand_score = '0; cand_id = '0; cand_last = 0;
    rd_en = 0; rd_row = '0; w_id_clear = 0; w_obj_valid = 0; w_obj_row = '0;
    m_next = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (res_valid !== 1'b0 || done_registration !== 1'b0) $display("FAIL reset_res_valid: got %b/%b want 0/0", res_valid, done_registration); else n_pass++;
    n_checks++; if (obj_ready !== 1'b0 || cand_ready !== 1'b0) $display("FAIL reset_ready: got %b/%b want 0/0", obj_ready, cand_ready); else n_pass++;
    n_checks++; if ({res_score0, res_id0, res_score1, res_id1, res_new_id, res_row} !== '0) $display("FAIL reset_res_fields: got nonzero want 0"); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else n_pass++;
    reset_N = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (obj_ready !== 1'b1 || cand_ready !== 1'b0) $display("FAIL reset_release_ready: got %b/%b want 1/0", obj_ready, cand_ready); else n_pass++;
  endtask

  task automatic test_first_frame();
    logic [FEAT_W-1:0] ft [3];
    for (int k = 0; k < 3; k++) begin
      ft[k] = FEAT_W'({$urandom, $urandom, $urandom, $urandom});
      model_decide(1'b1, 1'b0, 0);
      run_object(0, ft[k], k, 1'b0);
      n_checks++; if (cap_i0 !== ID_W'(k + 1)) $display("FAIL first_id0[%0d]: got %0d want %0d", k, cap_i0, k + 1); else n_pass++;
      n_checks++; if (cap_s0 !== '0 || cap_new !== 1'b1) $display("FAIL first_s0_new[%0d]: got %0d/%b want 0/1", k, cap_s0, cap_new); else n_pass++;
      n_checks++; if (lat !== 1) $display("FAIL first_latency[%0d]: got %0d want 1", k, lat); else n_pass++;
      n_checks++; if (cap_row !== ROW_W'(k)) $display("FAIL first_row[%0d]: got %0d want %0d", k, cap_row, k); else n_pass++;
    end
    n_checks++; if (res_valid !== 1'b0 || res_id0 !== ID_W'(3)) $display("FAIL first_hold: got valid %b id %0d want 0/3", res_valid, res_id0); else n_pass++;
    do_read(1);
    n_checks++; if (rd_data !== {ft[1], ID_W'(2)}) $display("FAIL first_readback: got %h want %h", rd_data, {ft[1], ID_W'(2)}); else n_pass++;
    rd_row = ROW_W'(2);
    @(posedge clk); #1;
    n_checks++; if (rd_data !== {ft[1], ID_W'(2)}) $display("FAIL readback_hold: got %h want %h", rd_data, {ft[1], ID_W'(2)}); else n_pass++;
  endtask

  task automatic test_tie();
    nb = 2;
    set_beat(0, 2'b11, 40, 7, 25, 9);
    set_beat(1, 2'b11, 30, 4, 25, 11);
    alloc_en = 1'b0;
    model_decide(1'b0, 1'b0, 0);
    run_object(5, FEAT_W'(120'h1111), 3, 1'b0);
    n_checks++; if (cap_s0 !== 16'd25 || cap_i0 !== 12'd9) $display("FAIL tie_best: got %0d/%0d want 25/9", cap_s0, cap_i0); else n_pass++;
    n_checks++; if (cap_s1 !== 16'd25 || cap_i1 !== 12'd11) $display("FAIL tie_second: got %0d/%0d want 25/11", cap_s1, cap_i1); else n_pass++;
    n_checks++; if (cap_new !== 1'b0 || lat !== 1) $display("FAIL tie_new_lat: got %b/%0d want 0/1", cap_new, lat); else n_pass++;
  endtask

  task automatic test_threshold();
    alloc_en = 1'b1; new_id_thresh = 16'd20;
    model_decide(1'b0, 1'b1, 20);
    run_object(5, FEAT_W'(120'h2222), 4, 1'b0);
    n_checks++; if (cap_i0 !== 12'd4 || cap_new !== 1'b1) $display("FAIL thresh_alloc: got %0d/%b want 4/1", cap_i0, cap_new); else n_pass++;
    n_checks++; if (cap_s0 !== 16'd25 || cap_s1 !== 16'd25 || cap_i1 !== 12'd9) $display("FAIL thresh_fields: got %0d/%0d/%0d want 25/25/9", cap_s0, cap_s1, cap_i1); else n_pass++;
  endtask

  task automatic test_empty_beat();
    nb = 1;
    set_beat(0, 2'b00, 3, 3, 3, 3);
    alloc_en = 1'b0;
    model_decide(1'b0, 1'b0, 0);
    run_object(5, FEAT_W'(120'h3333), 5, 1'b0);
    n_checks++; if (cap_i0 !== 12'd5 || cap_new !== 1'b1) $display("FAIL empty_alloc: got %0d/%b want 5/1", cap_i0, cap_new); else n_pass++;
    n_checks++; if (cap_s0 !== '0 || cap_i1 !== '0 || cap_s1 !== '0) $display("FAIL empty_fields: got %0d/%0d/%0d want 0/0/0", cap_s0, cap_i1, cap_s1); else n_pass++;
    do_read(4);
    n_checks++; if (rd_data !== {FEAT_W'(120'h2222), 12'd4}) $display("FAIL thresh_readback: got %h want %h", rd_data, {FEAT_W'(120'h2222), 12'd4}); else n_pass++;
  endtask

  task automatic test_random();
    int fr, th, rw;
    bit aen;
    for (int it = 0; it < 25; it++) begin
      fr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 100));
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++)
        set_beat(b, 2'($urandom), int'($urandom_range(0, 60)), int'($urandom_range(1, 4095)),
                 int'($urandom_range(0, 60)), int'($urandom_range(1, 4095)));
      aen = 1'($urandom); th = int'($urandom_range(0, 60)); rw = int'($urandom_range(0, ROWS - 1));
      alloc_en = aen; new_id_thresh = SCORE_W'(th);
      model_decide(fr == 0, aen, th);
      run_object(fr, FEAT_W'({$urandom, $urandom, $urandom, $urandom}), rw, 1'b0);
      n_checks++; if (cap_i0 !== ID_W'(e_i0) || cap_new !== e_new) $display("FAIL rand_id0[%0d]: got %0d/%b want %0d/%b", it, cap_i0, cap_new, e_i0, e_new); else n_pass++;
      n_checks++; if (cap_s0 !== SCORE_W'(e_s0)) $display("FAIL rand_s0[%0d]: got %0d want %0d", it, cap_s0, e_s0); else n_pass++;
      n_checks++; if (cap_s1 !== SCORE_W'(e_s1) || cap_i1 !== ID_W'(e_i1)) $display("FAIL rand_second[%0d]: got %0d/%0d want %0d/%0d", it, cap_s1, cap_i1, e_s1, e_i1); else n_pass++;
      n_checks++; if (lat !== 1) $display("FAIL rand_latency[%0d]: got %0d want 1", it, lat); else n_pass++;
    end
    for (int r = 0; r < int'(ROWS); r++)
      if (m_known[r]) begin
        do_read(r);
        n_checks++; if (rd_data !== m_mem[r]) $display("FAIL rand_readback[%0d]: got %h want %h", r, rd_data, m_mem[r]); else n_pass++;
      end
  endtask

  task automatic w_alloc(input bit clr, output int id, output bit nw);
    int cnt = 0;
    w_obj_valid = 1'b1; w_obj_row = 5'd7;
    while (!w_obj_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    w_obj_valid = 1'b0; w_id_clear = clr;
    @(posedge clk); #1;
    w_id_clear = 1'b0;
    id = int'(w_res_id0); nw = w_res_new_id & w_res_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_id_wrap();
    int id, want;
    bit nw;
    for (int k = 0; k < 8; k++) begin
      w_alloc(1'b0, id, nw);
      want = (k < 7) ? k + 1 : 1;
      n_checks++; if (id !== want || nw !== 1'b1) $display("FAIL wrap_id[%0d]: got %0d/%b want %0d/1", k, id, nw, want); else n_pass++;
    end
    w_alloc(1'b1, id, nw);
    n_checks++; if (id !== 2) $display("FAIL clear_coincident: got %0d want 2", id); else n_pass++;
    w_alloc(1'b0, id, nw);
    n_checks++; if (id !== 1) $display("FAIL clear_restart: got %0d want 1", id); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt = 0, seen = 0;
    frame_num = 16'd5; obj_feat = FEAT_W'(120'hdead); obj_row = 5'd3; obj_valid = 1'b1;
    while (!obj_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    obj_valid = 1'b0;
    cand_valid = 1'b1; cand_mask = 2'b01; cand_score = 32'd10; cand_id = 24'd9; cand_last = 1'b0;
    @(posedge clk); #1;
    cand_valid = 1'b0;
    reset_N = 1'b0; m_next = 1;
    #1;
    n_checks++; if (cand_ready !== 1'b0 || obj_ready !== 1'b0 || res_valid !== 1'b0) $display("FAIL midreset_outputs: got %b/%b/%b want 0/0/0", cand_ready, obj_ready, res_valid); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset_N = 1'b1;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (res_valid) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL midreset_res_valid: got %0d strobes want 0", seen); else n_pass++;
    n_checks++; if (obj_ready !== 1'b1) $display("FAIL midreset_obj_ready: got %b want 1", obj_ready); else n_pass++;
    do_read(3);
    n_checks++; if (rd_data !== m_mem[3]) $display("FAIL midreset_row: got %h want %h", rd_data, m_mem[3]); else n_pass++;
    model_decide(1'b1, 1'b0, 0);
    run_object(0, FEAT_W'(120'h4444), 6, 1'b0);
    n_checks++; if (cap_i0 !== 12'd1) $display("FAIL midreset_next_id: got %0d want 1", cap_i0); else n_pass++;
  endtask

  task automatic test_read_during_write();
    logic [FEAT_W+ID_W-1:0] first_word;
    model_decide(1'b1, 1'b0, 0);
    run_object(0, FEAT_W'(120'h5555), 10, 1'b0);
    first_word = m_mem[10];
    model_decide(1'b1, 1'b0, 0);
    run_object(0, FEAT_W'(120'h6666), 10, 1'b1);
    n_checks++; if (rd_data !== first_word) $display("FAIL rdw_old: got %h want %h", rd_data, first_word); else n_pass++;
    do_read(10);
    n_checks++; if (rd_data !== m_mem[10]) $display("FAIL rdw_new: got %h want %h", rd_data, m_mem[10]); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < int'(ROWS); r++) m_known[r] = 1'b0;
    test_reset();
    test_first_frame();
    test_tie();
    test_threshold();
    test_empty_beat();
    test_random();
    test_id_wrap();
    test_reset_mid();
    test_read_during_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
